// File: rtl/genius_core.sv
// genius_core -- Simon/"Genius" memory game engine.
//
// Each level appends one pseudo-random symbol to a stored sequence, replays the whole
// sequence on one-hot LEDs, then checks the player's presses against it. Win/lose flags
// and the current level go to the board-level display wrapper.
//
// Ports:
//   clock  in   system clock, rising edge
//   reset  in   asynchronous, active-high; returns to IDLE with all outputs low
//   start  in   level input; a registered rising edge starts a game from IDLE/WIN/LOSE
//   btn    in   raw active-high buttons, two-flop synchronised here
//   leds   out  one-hot replay symbol or press echo; all-ones in WIN; else 0
//   level  out  current sequence length (0 in IDLE)
//   busy   out  high while the sequence is being added/replayed (presses ignored)
//   win    out  high in WIN until the next game
//   lose   out  high in LOSE until the next game
//
// Optional feature macro: GENIUS_SPEEDUP_EN. When defined, show time halves every 4 levels
// and the press timeout halves every 8 levels (both floored at 1 cycle).

module genius_core #(
  parameter int unsigned NUM_BTNS       = 4,
  parameter int unsigned MAX_LEVEL      = 16,
  parameter int unsigned SHOW_CYCLES    = 8,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [15:0] SEED           = 16'hACE1,
  localparam int unsigned SymW          = $clog2(NUM_BTNS),
  localparam int unsigned LvlW          = $clog2(MAX_LEVEL + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [NUM_BTNS-1:0] btn,
  output logic [NUM_BTNS-1:0] leds,
  output logic [LvlW-1:0]     level,
  output logic                busy,
  output logic                win,
  output logic                lose
);

  localparam int unsigned AddrW = (MAX_LEVEL > 1) ? $clog2(MAX_LEVEL) : 1;
  localparam int unsigned TmrW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned PhMax = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int unsigned PhW   = $clog2(PhMax + 1);

  localparam logic [PhW-1:0]  GapLast  = PhW'(GAP_CYCLES - 1);
  localparam logic [LvlW-1:0] MaxLvl   = LvlW'(MAX_LEVEL);
  localparam logic [SymW:0]   NumSym   = (SymW + 1)'(NUM_BTNS);
  localparam logic [15:0]     LfsrTaps = 16'hB400;  // x^16 + x^14 + x^13 + x^11 + 1

  // StLead is the dark gap before the first replayed symbol of a level.
  typedef enum logic [3:0] {
    StIdle, StAdd, StLead, StShow, StGap, StWait, StRel, StWin, StLose
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         lfsr_q, lfsr_d, lfsr_next;
  logic                start_q;
  logic [NUM_BTNS-1:0] sync1_q, sync2_q, sync3_q;
  logic [LvlW-1:0]     level_q, level_d;
  logic [LvlW-1:0]     idx_q, idx_d;
  logic [PhW-1:0]      phase_q, phase_d;
  logic [TmrW-1:0]     timer_q, timer_d;
  logic [NUM_BTNS-1:0] echo_q, echo_d;

  logic [SymW-1:0]     seq_q [MAX_LEVEL];
  logic                seq_we;
  logic [SymW-1:0]     seq_rd, new_sym;
  logic [SymW:0]       sym_raw;
  logic [NUM_BTNS-1:0] exp_onehot, rise;
  logic                start_rise, press, released, last_idx;
  logic [PhW-1:0]      show_last;
  logic [TmrW-1:0]     tmo_last;

  assign lfsr_next  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrTaps : 16'h0000);
  assign start_rise = start & ~start_q;
  assign rise       = sync2_q & ~sync3_q;
  assign press      = |rise;
  assign released   = (sync2_q == '0);

  // Low LFSR bits can exceed the symbol range by less than NUM_BTNS; fold once.
  assign sym_raw = {1'b0, lfsr_q[SymW-1:0]};
  assign new_sym = (sym_raw >= NumSym) ? SymW'(sym_raw - NumSym) : lfsr_q[SymW-1:0];

  assign seq_rd     = seq_q[idx_q[AddrW-1:0]];
  assign exp_onehot = NUM_BTNS'(1) << seq_rd;
  assign last_idx   = (idx_q == level_q - LvlW'(1));

`ifdef GENIUS_SPEEDUP_EN
  logic [31:0] show_eff, tmo_eff;
  always_comb begin
    show_eff = 32'(SHOW_CYCLES) >> (level_q >> 2);
    if (show_eff == 32'd0) show_eff = 32'd1;
    tmo_eff = 32'(TIMEOUT_CYCLES) >> (level_q >> 3);
    if (tmo_eff == 32'd0) tmo_eff = 32'd1;
    show_last = PhW'(show_eff - 32'd1);
    tmo_last  = TmrW'(tmo_eff - 32'd1);
  end
`else
  assign show_last = PhW'(SHOW_CYCLES - 1);
  assign tmo_last  = TmrW'(TIMEOUT_CYCLES - 1);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      lfsr_q  <= SEED;
      start_q <= 1'b0;
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      level_q <= '0;
      idx_q   <= '0;
      phase_q <= '0;
      timer_q <= '0;
      echo_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      start_q <= start;
      sync1_q <= btn;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      level_q <= level_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      timer_q <= timer_d;
      echo_q  <= echo_d;
    end
  end

  always_ff @(posedge clock) begin
    if (seq_we) seq_q[level_q[AddrW-1:0]] <= new_sym;
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    level_d = level_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    timer_d = timer_q;
    echo_d  = echo_q;
    seq_we  = 1'b0;
    unique case (state_q)
      StIdle, StWin, StLose: begin
        lfsr_d = lfsr_next;
        if (start_rise) begin
          level_d = '0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        lfsr_d  = lfsr_next;
        seq_we  = 1'b1;
        level_d = level_q + LvlW'(1);
        idx_d   = '0;
        phase_d = '0;
        state_d = StLead;
      end
      StLead: begin
        if (phase_q == GapLast) begin
          phase_d = '0;
          idx_d   = '0;
          state_d = StShow;
        end else begin
          phase_d = phase_q + PhW'(1);
        end
      end
      StShow: begin
        if (phase_q == show_last) begin
          phase_d = '0;
          state_d = StGap;
        end else begin
          phase_d = phase_q + PhW'(1);
        end
      end
      StGap: begin
        if (phase_q == GapLast) begin
          phase_d = '0;
          if (!last_idx) begin
            idx_d   = idx_q + LvlW'(1);
            state_d = StShow;
          end else begin
            idx_d   = '0;
            timer_d = '0;
            state_d = StWait;
          end
        end else begin
          phase_d = phase_q + PhW'(1);
        end
      end
      StWait: begin
        timer_d = timer_q + TmrW'(1);
        if (press) begin
          // Exact match also rejects multi-button rises.
          if (rise == exp_onehot) begin
            echo_d  = rise;
            state_d = StRel;
          end else begin
            state_d = StLose;
          end
        end else if (timer_q == tmo_last) begin
          state_d = StLose;
        end
      end
      StRel: begin
        if (released) begin
          if (!last_idx) begin
            idx_d   = idx_q + LvlW'(1);
            timer_d = '0;
            state_d = StWait;
          end else if (level_q == MaxLvl) begin
            state_d = StWin;
          end else begin
            state_d = StAdd;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    leds = '0;
    busy = 1'b0;
    unique case (state_q)
      StAdd, StLead, StGap: busy = 1'b1;
      StShow: begin
        busy = 1'b1;
        leds = exp_onehot;
      end
      StRel:   leds = echo_q;
      StWin:   leds = '1;
      default: ;
    endcase
  end

  assign level = level_q;
  assign win   = (state_q == StWin);
  assign lose  = (state_q == StLose);

endmodule
